// File: rtl/msrv32_pkg.sv
// Shared types and constants for the handshaked store unit: FSM state,
// store-size (funct3) encodings and byte-lane mask patterns.
package msrv32_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } store_state_t;

  localparam logic [1:0] F3_SB  = 2'b00;
  localparam logic [1:0] F3_SH  = 2'b01;
  localparam logic [1:0] F3_SW  = 2'b10;
  localparam logic [1:0] F3_BAD = 2'b11;

  localparam logic [3:0] MASK_SB    = 4'b0001;
  localparam logic [3:0] MASK_SH_LO = 4'b0011;
  localparam logic [3:0] MASK_SH_HI = 4'b1100;
  localparam logic [3:0] MASK_SW    = 4'b1111;

  function automatic logic f3_valid(input logic [1:0] f3);
    return f3 != F3_BAD;
  endfunction

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Combinational byte-lane steering: replicates store data across lanes and
// builds the byte-enable mask from store size and the low address bits.
module msrv32_store_lane_gen
  import msrv32_pkg::*;
(
  input  logic [1:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave it unassigned (no latch).
    data = '0;
    mask = '0;
    case (funct3)
      F3_SB: begin
        data = {4{rs2[7:0]}};
        mask = MASK_SB << addr_lo;
      end
      F3_SH: begin
        data = {2{rs2[15:0]}};
        mask = addr_lo[1] ? MASK_SH_HI : MASK_SH_LO;
      end
      F3_SW: begin
        data = rs2;
        mask = MASK_SW;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msrv32_store_unit_hs.sv
// Data-memory write master: captures one store, holds it on a req/ack bus
// until accepted or timed out, stalls the pipeline, pulses done/fault.
module msrv32_store_unit_hs
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ms_riscv32_mp_dmwr_ack_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic        store_stall_out,
  output logic        store_done_out,
  output logic        store_fault_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  store_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]    addr_q;
  logic [31:0]    data_q;
  logic [3:0]     mask_q;
  logic           done_q;
  logic           fault_q;

  logic [31:0]    lane_data;
  logic [3:0]     lane_mask;
  logic           busy;
  logic           ack;
  logic           idle_go;
  logic           idle_bad;
  logic           timeout_hit;

  msrv32_store_lane_gen u_lane_gen (
    .funct3  (funct3_in),
    .addr_lo (iadder_in[1:0]),
    .rs2     (rs2_in),
    .data    (lane_data),
    .mask    (lane_mask)
  );

  assign busy        = (state == ST_BUSY);
  assign ack         = ms_riscv32_mp_dmwr_ack_in;
  assign idle_go     = ~busy & mem_wr_req_in & f3_valid(funct3_in);
  assign idle_bad    = ~busy & mem_wr_req_in & ~f3_valid(funct3_in);
  assign timeout_hit = busy & (TIMEOUT_CYCLES != 0) & (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_go) begin
            state  <= ST_BUSY;
            cnt    <= '0;
            addr_q <= {iadder_in[31:2], 2'b00};
            data_q <= lane_data;
            mask_q <= lane_mask;
          end else if (idle_bad) begin
            fault_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (ack) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else if (timeout_hit) begin
            state   <= ST_IDLE;
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus fields read as zero whenever no write is being offered.
  assign ms_riscv32_mp_dmwr_req_out  = busy;
  assign ms_riscv32_mp_dmaddr_out    = busy ? addr_q : '0;
  assign ms_riscv32_mp_dmdata_out    = busy ? data_q : '0;
  assign ms_riscv32_mp_dmwr_mask_out = busy ? mask_q : '0;
  assign store_stall_out             = idle_go | (busy & ~ack & ~timeout_hit);
  assign store_done_out              = done_q;
  assign store_fault_out             = fault_q;

endmodule
